// File: rtl/clint_rtc_pkg.sv
// ---------------------------------------------------------------------------
// clint_rtc_pkg
// Shared helpers for the CLINT RTC generator: derivation of the phase
// increment from clock/RTC frequencies and the largest legal increment.
// Also used by the testbench as the reference for the default increment.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package clint_rtc_pkg;

    // floor(2 * rtc_hz * 2^acc_w / clk_hz). The factor of two is because one
    // accumulator wrap produces one rtc_o edge, i.e. half an RTC period.
    function automatic logic [127:0] calc_rtc_inc(input logic [127:0] clk_hz,
                                                  input logic [127:0] rtc_hz,
                                                  input int           acc_w);
        logic [127:0] num;
        num = (rtc_hz << 1) << acc_w;
        return num / clk_hz;
    endfunction

    // Largest increment that still keeps every rtc_o level >= 2 aclk cycles.
    function automatic logic [127:0] RTC_INC_MAX(input int acc_w);
        return 128'(1) << (acc_w - 1);
    endfunction

endpackage

// File: rtl/clint_rtc_gen.sv
// ---------------------------------------------------------------------------
// clint_rtc_gen
// Phase-accumulator NCO producing the RTC square wave for the CLINT rtc input.
// Each accumulator carry toggles rtc_o; rising edges are flagged and counted.
//
// Ports
//   aclk        clock
//   aresetn     asynchronous active-low reset
//   en_i        generator enable (low: phase and rtc_o cleared, count held)
//   halt_i      debug freeze, holds all state; wins over en_i
//   inc_load_i  load inc_i (saturated) into the increment register
//   inc_i       new increment value
//   inc_o       current increment register
//   rtc_o       RTC square wave
//   rtc_rise_o  one-cycle pulse on the cycle rtc_o goes 0->1
//   rtc_cnt_o   number of rtc_o rising edges since reset (wraps)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module clint_rtc_gen
    import clint_rtc_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int RTC_FREQ_HZ = 1000000,
    parameter int ACC_WIDTH   = 32,
    parameter int CNT_WIDTH   = 64
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 en_i,
    input  logic                 halt_i,
    input  logic                 inc_load_i,
    input  logic [ACC_WIDTH-1:0] inc_i,
    output logic [ACC_WIDTH-1:0] inc_o,
    output logic                 rtc_o,
    output logic                 rtc_rise_o,
    output logic [CNT_WIDTH-1:0] rtc_cnt_o
);

    localparam logic [127:0] INC_DEFAULT_W =
        calc_rtc_inc(128'(CLK_FREQ_HZ), 128'(RTC_FREQ_HZ), ACC_WIDTH);
    localparam logic [127:0] INC_MAX_W = RTC_INC_MAX(ACC_WIDTH);

    localparam logic [ACC_WIDTH-1:0] INC_DEFAULT = INC_DEFAULT_W[ACC_WIDTH-1:0];
    localparam logic [ACC_WIDTH-1:0] INC_MAX     = INC_MAX_W[ACC_WIDTH-1:0];

    // A zero increment never ticks; one above half-scale would allow
    // single-cycle rtc_o levels that the CLINT synchroniser can miss.
    if (INC_DEFAULT_W == 128'd0 || INC_DEFAULT_W > INC_MAX_W) begin : g_inc_range
        $error("clint_rtc_gen: default increment %0d outside 1..%0d",
               INC_DEFAULT_W, INC_MAX_W);
    end

    function automatic logic [ACC_WIDTH-1:0] sat_inc(input logic [ACC_WIDTH-1:0] v);
        return (v > INC_MAX) ? INC_MAX : v;
    endfunction

    logic [ACC_WIDTH-1:0] acc_p1;
    logic [ACC_WIDTH-1:0] inc_p1;
    logic [ACC_WIDTH:0]   sum_p0;

    // ---- stage 0: phase add, MSB is the carry that toggles rtc_o ----
    assign sum_p0 = {1'b0, acc_p1} + {1'b0, inc_p1};

    // ---- stage 1: registered phase, wave, edge pulse and counter ----
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            inc_p1     <= INC_DEFAULT;
            acc_p1     <= '0;
            rtc_o      <= 1'b0;
            rtc_rise_o <= 1'b0;
            rtc_cnt_o  <= '0;
        end else begin
            // The add above already uses the old increment in a load cycle.
            if (inc_load_i) begin
                inc_p1 <= sat_inc(inc_i);
            end

            if (halt_i) begin
                rtc_rise_o <= 1'b0;
            end else if (!en_i) begin
                acc_p1     <= '0;
                rtc_o      <= 1'b0;
                rtc_rise_o <= 1'b0;
            end else begin
                acc_p1     <= sum_p0[ACC_WIDTH-1:0];
                rtc_rise_o <= sum_p0[ACC_WIDTH] & ~rtc_o;
                if (sum_p0[ACC_WIDTH]) begin
                    rtc_o <= ~rtc_o;
                    if (!rtc_o) begin
                        rtc_cnt_o <= rtc_cnt_o + CNT_WIDTH'(1);
                    end
                end
            end
        end
    end

    assign inc_o = inc_p1;

endmodule
